// File: rtl/rf_pkg.sv
// Shared register-file constants, requester indices and the write-port command payload.
package rf_pkg;

  localparam int unsigned ADDR_BITS = 5;
  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned REG_SIZE  = 1 << ADDR_BITS;

  localparam logic [ADDR_BITS-1:0] REG_ZERO = '0;

  // Writeback requester slots on the arbiter
  localparam int unsigned REQ_ALU  = 0;
  localparam int unsigned REQ_LOAD = 1;
  localparam int unsigned REQ_CSR  = 2;

  typedef struct packed {
    logic                 en;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } wr_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr,
// wrapping; no grant while hold is high.
module rr_arbiter #(
  parameter  int unsigned N     = 3,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             hold,
  output logic [N-1:0]     grant
);

  logic found;

  // First pass covers [ptr, N-1]; second pass wraps to [0, ptr-1].
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (!hold) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req[i] && (i >= 32'(ptr))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with a pending-write scoreboard for RAW hazard detection.
// Optional write-port forwarding outputs are built when RF_WB_FWD_EN is defined.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                           CLKA,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic                           wr_hold,
  output logic                           wr_en,
  output logic [ADDR_BITS-1:0]           wr_addr,
  output logic [DATA_BITS-1:0]           wr_data,
  input  logic                           alloc_valid,
  input  logic [ADDR_BITS-1:0]           alloc_addr,
  input  logic [ADDR_BITS-1:0]           rs1_addr,
  input  logic [ADDR_BITS-1:0]           rs2_addr,
  output logic                           rs1_busy,
  output logic                           rs2_busy,
`ifdef RF_WB_FWD_EN
  output logic                           fwd1_hit,
  output logic [DATA_BITS-1:0]           fwd1_data,
  output logic                           fwd2_hit,
  output logic [DATA_BITS-1:0]           fwd2_data,
`endif
  output logic [REG_SIZE-1:0]            busy_vec
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]     ptr_q, ptr_d;
  wr_cmd_t              wr_q, wr_d;
  logic [REG_SIZE-1:0]  busy_q, busy_d;

  logic [NUM_REQ-1:0]   grant;
  logic                 accept;
  logic [PTR_W-1:0]     sel_idx;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_data;

  // Reset also blocks grants so no requester sees ready while rst is high.
  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .hold  (wr_hold | rst),
    .grant (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // Select the granted requester's slice of the packed address/data buses.
  always_comb begin
    sel_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_idx  = PTR_W'(i);
        sel_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_data = req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Next state: pointer, write command and scoreboard; an alloc overrides a same-register clear.
  always_comb begin
    ptr_d   = ptr_q;
    wr_d    = wr_q;
    wr_d.en = 1'b0;
    busy_d  = busy_q;
    if (accept) begin
      ptr_d            = (32'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + PTR_W'(1);
      wr_d.en          = (sel_addr != REG_ZERO);
      wr_d.addr        = sel_addr;
      wr_d.data        = sel_data;
      busy_d[sel_addr] = 1'b0;
    end
    if (alloc_valid && (alloc_addr != REG_ZERO)) begin
      busy_d[alloc_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLKA or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      wr_q   <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      wr_q   <= wr_d;
      busy_q <= busy_d;
    end
  end

  assign wr_en    = wr_q.en;
  assign wr_addr  = wr_q.addr;
  assign wr_data  = wr_q.data;
  assign busy_vec = busy_q;

`ifdef RF_WB_FWD_EN
  // A write sitting on the port is not yet in the register file; forward it instead of stalling.
  assign fwd1_hit  = wr_q.en && (wr_q.addr == rs1_addr) && (rs1_addr != REG_ZERO);
  assign fwd2_hit  = wr_q.en && (wr_q.addr == rs2_addr) && (rs2_addr != REG_ZERO);
  assign fwd1_data = wr_q.data;
  assign fwd2_data = wr_q.data;
  assign rs1_busy  = busy_q[rs1_addr] && !fwd1_hit;
  assign rs2_busy  = busy_q[rs2_addr] && !fwd2_hit;
`else
  assign rs1_busy  = busy_q[rs1_addr];
  assign rs2_busy  = busy_q[rs2_addr];
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a behavioural model. Honors RF_WB_FWD_EN when defined.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int unsigned N = 3;

  logic                   CLKA = 1'b0;
  logic                   rst;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_ready;
  logic [N*ADDR_BITS-1:0] req_addr;
  logic [N*DATA_BITS-1:0] req_data;
  logic                   wr_hold;
  logic                   wr_en;
  logic [ADDR_BITS-1:0]   wr_addr;
  logic [DATA_BITS-1:0]   wr_data;
  logic                   alloc_valid;
  logic [ADDR_BITS-1:0]   alloc_addr;
  logic [ADDR_BITS-1:0]   rs1_addr;
  logic [ADDR_BITS-1:0]   rs2_addr;
  logic                   rs1_busy;
  logic                   rs2_busy;
  logic [REG_SIZE-1:0]    busy_vec;
`ifdef RF_WB_FWD_EN
  logic                   fwd1_hit;
  logic [DATA_BITS-1:0]   fwd1_data;
  logic                   fwd2_hit;
  logic [DATA_BITS-1:0]   fwd2_data;
`endif

  rf_wb_arbiter #(.NUM_REQ(N)) dut (
    .CLKA        (CLKA),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .wr_hold     (wr_hold),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
`ifdef RF_WB_FWD_EN
    .fwd1_hit    (fwd1_hit),
    .fwd1_data   (fwd1_data),
    .fwd2_hit    (fwd2_hit),
    .fwd2_data   (fwd2_data),
`endif
    .busy_vec    (busy_vec)
  );

  always #5 CLKA = ~CLKA;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and let combinational outputs settle.
  task automatic apply(input logic [N-1:0] v, input logic [N*ADDR_BITS-1:0] a,
                       input logic [N*DATA_BITS-1:0] d, input logic h, input logic av,
                       input logic [ADDR_BITS-1:0] aa, input logic [ADDR_BITS-1:0] r1,
                       input logic [ADDR_BITS-1:0] r2);
    @(negedge CLKA);
    req_valid = v; req_addr = a; req_data = d; wr_hold = h;
    alloc_valid = av; alloc_addr = aa; rs1_addr = r1; rs2_addr = r2;
    #1;
  endtask

  task automatic idle(input logic [ADDR_BITS-1:0] r1, input logic [ADDR_BITS-1:0] r2);
    apply('0, '0, '0, 1'b0, 1'b0, '0, r1, r2);
  endtask

  task automatic do_reset();
    @(negedge CLKA);
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0; wr_hold = 1'b0;
    alloc_valid = 1'b0; alloc_addr = '0; rs1_addr = '0; rs2_addr = '0;
    @(negedge CLKA);
    rst = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  int                   m_ptr;
  logic [REG_SIZE-1:0]  m_busy;
  logic                 m_wr_en;
  logic [ADDR_BITS-1:0] m_wr_addr;
  logic [DATA_BITS-1:0] m_wr_data;

  function automatic int exp_grant(input logic [N-1:0] v, input logic h, input int ptr);
    if (h) return -1;
    for (int k = 0; k < int'(N); k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_busy = '0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
  endtask

  task automatic model_check();
    int   g;
    logic h1, h2;
    logic [N-1:0] er;
    g  = exp_grant(req_valid, wr_hold, m_ptr);
    er = (g < 0) ? '0 : N'(1) << g;
    h1 = 1'b0; h2 = 1'b0;
`ifdef RF_WB_FWD_EN
    h1 = m_wr_en && (m_wr_addr == rs1_addr) && (rs1_addr != 0);
    h2 = m_wr_en && (m_wr_addr == rs2_addr) && (rs2_addr != 0);
    check("rnd_fwd1_hit", 64'(fwd1_hit), 64'(h1));
    check("rnd_fwd2_hit", 64'(fwd2_hit), 64'(h2));
    if (h1) check("rnd_fwd1_data", 64'(fwd1_data), 64'(m_wr_data));
`endif
    check("rnd_ready", 64'(req_ready), 64'(er));
    check("rnd_wr_en", 64'(wr_en), 64'(m_wr_en));
    check("rnd_wr_addr", 64'(wr_addr), 64'(m_wr_addr));
    check("rnd_wr_data", 64'(wr_data), 64'(m_wr_data));
    check("rnd_busy_vec", 64'(busy_vec), 64'(m_busy));
    check("rnd_rs1_busy", 64'(rs1_busy), 64'(m_busy[rs1_addr] && !h1));
    check("rnd_rs2_busy", 64'(rs2_busy), 64'(m_busy[rs2_addr] && !h2));
  endtask

  task automatic model_edge();
    int g;
    logic [ADDR_BITS-1:0] a;
    g = exp_grant(req_valid, wr_hold, m_ptr);
    m_wr_en = 1'b0;
    if (g >= 0) begin
      a         = req_addr[g*ADDR_BITS +: ADDR_BITS];
      m_ptr     = (g + 1) % N;
      m_wr_en   = (a != 0);
      m_wr_addr = a;
      m_wr_data = req_data[g*DATA_BITS +: DATA_BITS];
      m_busy[a] = 1'b0;
    end
    if (alloc_valid && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [N-1:0]           valid;
    logic                   hold;
    logic [N*ADDR_BITS-1:0] addrs;
    logic [N*DATA_BITS-1:0] datas;
    logic [N-1:0]           exp_ready;
    logic                   exp_en;
    logic [ADDR_BITS-1:0]   exp_addr;
    logic [DATA_BITS-1:0]   exp_data;
  } vec_t;

  localparam logic [31:0] DA = 32'hAAAA_0001;
  localparam logic [31:0] DB = 32'hBBBB_0002;
  localparam logic [31:0] DC = 32'hCCCC_0003;
  localparam logic [31:0] DD = 32'hDDDD_0009;
  localparam logic [31:0] DZ = 32'hDEAD_BEEF;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{3'b111, 1'b0, {5'd3, 5'd2, 5'd1}, {DC, DB, DA}, 3'b001, 1'b0, 5'd0, 32'd0};
    tbl[1] = '{3'b111, 1'b0, {5'd3, 5'd2, 5'd1}, {DC, DB, DA}, 3'b010, 1'b1, 5'd1, DA};
    tbl[2] = '{3'b111, 1'b0, {5'd3, 5'd2, 5'd1}, {DC, DB, DA}, 3'b100, 1'b1, 5'd2, DB};
    tbl[3] = '{3'b000, 1'b0, '0, '0, 3'b000, 1'b1, 5'd3, DC};
    tbl[4] = '{3'b001, 1'b1, {5'd0, 5'd0, 5'd9}, {32'd0, 32'd0, DD}, 3'b000, 1'b0, 5'd3, DC};
    tbl[5] = '{3'b001, 1'b1, {5'd0, 5'd0, 5'd9}, {32'd0, 32'd0, DD}, 3'b000, 1'b0, 5'd3, DC};
    tbl[6] = '{3'b001, 1'b0, {5'd0, 5'd0, 5'd9}, {32'd0, 32'd0, DD}, 3'b001, 1'b0, 5'd3, DC};
    tbl[7] = '{3'b011, 1'b0, {5'd0, 5'd0, 5'd9}, {32'd0, DZ, DD}, 3'b010, 1'b1, 5'd9, DD};
    tbl[8] = '{3'b000, 1'b0, '0, '0, 3'b000, 1'b0, 5'd0, DZ};

    // Reset holds ready low even with every requester valid.
    rst = 1'b1;
    req_valid = '1; req_addr = {5'd3, 5'd2, 5'd1}; req_data = '0; wr_hold = 1'b0;
    alloc_valid = 1'b0; alloc_addr = '0; rs1_addr = '0; rs2_addr = '0;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_busy", 64'(busy_vec), 64'd0);
    do_reset();

    foreach (tbl[i]) begin
      apply(tbl[i].valid, tbl[i].addrs, tbl[i].datas, tbl[i].hold, 1'b0, '0, '0, '0);
      check($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].exp_ready));
      check($sformatf("tbl%0d_wr_en", i), 64'(wr_en), 64'(tbl[i].exp_en));
      check($sformatf("tbl%0d_wr_addr", i), 64'(wr_addr), 64'(tbl[i].exp_addr));
      check($sformatf("tbl%0d_wr_data", i), 64'(wr_data), 64'(tbl[i].exp_data));
    end

    // Scoreboard: alloc and write to the same register in one cycle leaves it busy.
    do_reset();
    apply('0, '0, '0, 1'b0, 1'b1, 5'd5, 5'd5, '0);
    check("sb_no_bypass", 64'(rs1_busy), 64'd0);
    apply(3'b001, {10'd0, 5'd5}, {64'd0, 32'h55}, 1'b0, 1'b1, 5'd5, 5'd5, '0);
    check("sb_busy_set", 64'(busy_vec), 64'h20);
    check("sb_rs1_busy", 64'(rs1_busy), 64'd1);
    idle(5'd5, '0);
    check("sb_race_busy", 64'(busy_vec), 64'h20);
    check("sb_race_wr_en", 64'(wr_en), 64'd1);
`ifdef RF_WB_FWD_EN
    check("sb_race_rs1", 64'(rs1_busy), 64'd0);
`else
    check("sb_race_rs1", 64'(rs1_busy), 64'd1);
`endif
    idle(5'd5, '0);
    check("sb_hold_rs1", 64'(rs1_busy), 64'd1);
    // Clear of 5 and set of 6 in the same cycle both land.
    apply(3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'h66, 32'd0}, 1'b0, 1'b1, 5'd6, '0, '0);
    check("sb_ready_ptr1", 64'(req_ready), 64'b010);
    idle(5'd5, 5'd6);
    check("sb_mixed_busy", 64'(busy_vec), 64'h40);
    check("sb_mixed_rs1", 64'(rs1_busy), 64'd0);
    check("sb_mixed_rs2", 64'(rs2_busy), 64'd1);
    apply(3'b100, {5'd6, 10'd0}, {32'h61, 64'd0}, 1'b0, 1'b1, 5'd0, 5'd0, '0);
    check("sb_ready_ptr2", 64'(req_ready), 64'b100);
    check("sb_rs0_busy", 64'(rs1_busy), 64'd0);
    apply(3'b001, {10'd0, 5'd3}, {64'd0, 32'h77}, 1'b0, 1'b1, 5'd4, '0, '0);
    check("sb_zero_alloc", 64'(busy_vec), 64'd0);

    // Reset mid-operation drops the pending write and every reservation immediately.
    idle('0, '0);
    check("mid_busy_pre", 64'(busy_vec), 64'h10);
    check("mid_wr_en_pre", 64'(wr_en), 64'd1);
    check("mid_wr_addr_pre", 64'(wr_addr), 64'd3);
    req_valid = '1;
    rst = 1'b1;
    #1;
    check("mid_wr_en", 64'(wr_en), 64'd0);
    check("mid_wr_addr", 64'(wr_addr), 64'd0);
    check("mid_wr_data", 64'(wr_data), 64'd0);
    check("mid_busy", 64'(busy_vec), 64'd0);
    check("mid_ready", 64'(req_ready), 64'd0);
    @(negedge CLKA);
    req_valid = '0;
    rst = 1'b0;
    #1;
    check("mid_busy_post", 64'(busy_vec), 64'd0);

    // Write of 0x1234 to r7 with rs2 querying r7 during the write-port cycle.
    apply('0, '0, '0, 1'b0, 1'b1, 5'd7, '0, 5'd7);
    apply(3'b001, {10'd0, 5'd7}, {64'd0, 32'h1234}, 1'b0, 1'b0, '0, '0, 5'd7);
    check("fwd_pre_busy", 64'(rs2_busy), 64'd1);
    idle('0, 5'd7);
    check("fwd_wr_en", 64'(wr_en), 64'd1);
    check("fwd_wr_data", 64'(wr_data), 64'h1234);
    check("fwd_rs2_busy", 64'(rs2_busy), 64'd0);
`ifdef RF_WB_FWD_EN
    check("fwd2_hit", 64'(fwd2_hit), 64'd1);
    check("fwd2_data", 64'(fwd2_data), 64'h1234);
    check("fwd1_hit_r0", 64'(fwd1_hit), 64'd0);
`endif

    // Randomized traffic against the model; small address range forces collisions.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic [N*ADDR_BITS-1:0] ra;
      logic [N*DATA_BITS-1:0] rd;
      for (int i = 0; i < int'(N); i++) begin
        ra[i*ADDR_BITS +: ADDR_BITS] = ADDR_BITS'($urandom_range(0, 7));
        rd[i*DATA_BITS +: DATA_BITS] = $urandom;
      end
      apply(N'($urandom), ra, rd, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1), ADDR_BITS'($urandom_range(0, 7)),
            ADDR_BITS'($urandom_range(0, 7)), ADDR_BITS'($urandom_range(0, 7)));
      model_check();
      model_edge();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Arbitrates the register file's single write port between NUM_REQ writeback requesters (ALU, load unit, CSR unit) using round-robin, with a valid/ready handshake. Drives a registered write command (wr_en, wr_addr, wr_data) straight into the register file write port. Also keeps a per-register pending-write scoreboard so the issue stage can detect read-after-write hazards on the two read addresses.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..4)
ADDR_BITS, 5, register address width
DATA_BITS, 32, register data width
REG_SIZE, 32, number of architectural registers (2**ADDR_BITS)

Ports:
CLKA  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  NUM_REQ  requester i has a writeback pending
req_ready  output  NUM_REQ  one-hot grant; req i accepted when valid&ready
req_addr  input  NUM_REQ*ADDR_BITS  packed destination register, req i at [i*ADDR_BITS +: ADDR_BITS]
req_data  input  NUM_REQ*DATA_BITS  packed write data, same packing
wr_hold  input  1  register file write port unavailable; no grants this cycle
wr_en  output  1  register file write enable (registered)
wr_addr  output  ADDR_BITS  register file write address (registered)
wr_data  output  DATA_BITS  register file write data (registered)
alloc_valid  input  1  issue stage reserves a destination register
alloc_addr  input  ADDR_BITS  register being reserved
rs1_addr  input  ADDR_BITS  hazard query address 1
rs2_addr  input  ADDR_BITS  hazard query address 2
rs1_busy  output  1  rs1_addr has a pending write (combinational from busy_vec)
rs2_busy  output  1  rs2_addr has a pending write
busy_vec  output  REG_SIZE  scoreboard, bit r = pending write to register r

Behaviour:
- Reset (async): wr_en=0, wr_addr=0, wr_data=0, busy_vec=0, rr pointer=0. req_ready=0 while rst is high.
- Arbitration is combinational. If wr_hold=1, req_ready=0. Otherwise exactly one req_ready bit is high: the first valid requester searching from index ptr upward, wrapping. If no requester is valid, req_ready=0.
- Pointer: after an accept from requester i, ptr <= (i+1) mod NUM_REQ. With no accept, ptr holds.
- Write latency is 1 cycle. On an accept at edge N, wr_en=1, wr_addr=req_addr[i] and wr_data=req_data[i] for the cycle following edge N. Otherwise wr_en=0, and wr_addr/wr_data hold their previous values.
- Address 0: the request is still accepted (ready asserted), but wr_en stays 0. The register stays hardwired to zero.
- Scoreboard set: when alloc_valid=1 and alloc_addr!=0, busy_vec[alloc_addr] is set at the next edge.
- Scoreboard clear: an accepted request to register r clears busy_vec[r] at the same edge it registers wr_en.
- Simultaneous set and clear of the same register: set wins, because the newer instruction owns it. Set and clear of different registers both take effect.
- Register 0: busy_vec[0] is constant 0, so rs*_busy for address 0 is always 0.
- rsX_busy = busy_vec[rsX_addr]. No same-cycle bypass of alloc or clear.
- Holding a request: a requester keeps valid, addr and data stable until accepted. The arbiter does not check this; it is a requester obligation.
- Reset mid-operation: any registered write is discarded (wr_en forced 0) and all pending reservations are dropped.

Optional Feature:
RF_WB_FWD_EN
- Defined: adds outputs fwd1_hit, fwd1_data, fwd2_hit, fwd2_data (DATA_BITS).
- fwdX_hit = wr_en & (wr_addr==rsX_addr) & (rsX_addr!=0), and fwdX_data = wr_data. This covers the cycle where the register file has not yet captured the write.
- Hazard outputs change when defined: rsX_busy is also masked by fwdX_hit.
- Undefined: the ports are absent and rsX_busy is as above.

Decomposition:
- Shared package rf_pkg holds ADDR_BITS, DATA_BITS, REG_SIZE, the zero-register constant, and requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_CSR=2.
- One sub-module, rr_arbiter: parameter N, inputs req, ptr and hold, output one-hot grant. It is reusable by other shared resources.
- The scoreboard and output register stay in the top module.

Test Plan:
- Reset: assert rst mid-stream with busy_vec=0x0000_0010 and wr_en=1. Outputs go to 0 immediately, and busy_vec=0 after release.
- Round-robin: all 3 valid for 3 cycles with addrs 1, 2, 3 and data A, B, C. Grants are 0, 1, 2 in order, and wr_en/wr_addr are 1,2,3 each one cycle later with data A,B,C.
- wr_hold: wr_hold=1 for 2 cycles with req0 valid. req_ready=0 and wr_en=0; after release, req0 is granted, then a write to its address follows.
- Zero register: req1 writes addr 0 with data 0xDEAD_BEEF. req_ready[1]=1 and wr_en stays 0.
- Scoreboard race: alloc addr 5 and an accepted write to addr 5 in the same cycle leave busy_vec[5]=1 and rs1_busy=1 for rs1_addr=5. A later write to addr 5 clears the bit.
- RF_WB_FWD_EN: a write of 0x1234 to addr 7 with rs2_addr=7 gives fwd2_hit=1, fwd2_data=0x1234 and rs2_busy=0 in the wr_en cycle.
